trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 39 +++
 rtl/trap_ctrl_irq_prio.sv | 42 ++++
 rtl/trap_ctrl.sv | 148 ++++++++++++++
 tb/tb_trap_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared CSR-side definitions for the trap controller: FSM state encoding,
// interrupt cause codes, mie bit positions and a small helper that reports
// whether a given interrupt cause is still pending and enabled.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    // mcause interrupt codes
    localparam logic [3:0] CAUSE_M_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_M_SW    = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;

    // mie enable bit indices
    localparam int MIE_MEIE = 11;
    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;

    // True when the interrupt identified by code is still requesting service.
    function automatic logic irq_live(input logic [3:0] code,
                                      input logic       ext_pend,
                                      input logic       sw_pend,
                                      input logic       timer_pend);
        logic live;
        live = 1'b0;
        case (code)
            CAUSE_M_EXT:   live = ext_pend;
            CAUSE_M_SW:    live = sw_pend;
            CAUSE_M_TIMER: live = timer_pend;
            default:       live = 1'b0;
        endcase
        return live;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Combinational interrupt selector.
// Inputs : irq_ext/irq_sw/irq_timer level lines, mstatus_mie, mie CSR.
// Outputs: irq_valid (some enabled interrupt pending), irq_cause (full
//          64-bit mcause, bit 63 set) of the highest priority one:
//          ext > sw > timer.
module irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic [63:0] mie,
    output logic        irq_valid,
    output logic [63:0] irq_cause
);

    logic ext_en, sw_en, timer_en;

    assign ext_en   = mstatus_mie & mie[MIE_MEIE] & irq_ext;
    assign sw_en    = mstatus_mie & mie[MIE_MSIE] & irq_sw;
    assign timer_en = mstatus_mie & mie[MIE_MTIE] & irq_timer;

    always_comb begin
        irq_valid = 1'b0;
        irq_cause = '0;
        if (ext_en) begin
            irq_valid = 1'b1;
            irq_cause = {1'b1, 59'd0, CAUSE_M_EXT};
        end else if (sw_en) begin
            irq_valid = 1'b1;
            irq_cause = {1'b1, 59'd0, CAUSE_M_SW};
        end else if (timer_en) begin
            irq_valid = 1'b1;
            irq_cause = {1'b1, 59'd0, CAUSE_M_TIMER};
        end
    end

    logic unused_mie;
    assign unused_mie = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: sequences synchronous exceptions, MRET and interrupts
// through IDLE -> (DRAIN) -> COMMIT -> REDIRECT -> IDLE.
// Inputs : exc_valid/exc_code/exc_pc (W-stage exception), mret_valid,
//          irq_ext/irq_sw/irq_timer, mstatus_mie, mie, commit_pc(_valid),
//          pipe_busy.
// Outputs: stall_fetch, trap_req/trap_cause/trap_epc, mret_req, flush,
//          redirect_valid/redirect_sel (0 = mtvec, 1 = mepc), busy.
// All outputs are decoded from the state register and latched registers.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int MIN_DRAIN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_pc,
    input  logic        mret_valid,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic [63:0] mie,
    input  logic [63:0] commit_pc,
    input  logic        commit_pc_valid,
    input  logic        pipe_busy,
    output logic        stall_fetch,
    output logic        trap_req,
    output logic [63:0] trap_cause,
    output logic [63:0] trap_epc,
    output logic        mret_req,
    output logic        flush,
    output logic        redirect_valid,
    output logic        redirect_sel,
    output logic        busy
);

    // Drain exit threshold; counter saturates there since larger values
    // carry no extra information.
    localparam int THR = (MIN_DRAIN > 0) ? MIN_DRAIN - 1 : 0;
    localparam int CW  = (THR > 0) ? $clog2(THR + 1) : 1;

    trap_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   cause_q, cause_d;
    logic [63:0]   epc_q, epc_d;
    logic          is_mret_q, is_mret_d;

    logic        irq_valid;
    logic [63:0] irq_cause;
    logic        ext_pend, sw_pend, timer_pend, latched_live;

    irq_prio u_irq_prio (
        .irq_ext     (irq_ext),
        .irq_sw      (irq_sw),
        .irq_timer   (irq_timer),
        .mstatus_mie (mstatus_mie),
        .mie         (mie),
        .irq_valid   (irq_valid),
        .irq_cause   (irq_cause)
    );

    // Liveness of the specific interrupt being drained for, independent of
    // whichever interrupt currently wins priority.
    assign ext_pend     = mstatus_mie & mie[MIE_MEIE] & irq_ext;
    assign sw_pend      = mstatus_mie & mie[MIE_MSIE] & irq_sw;
    assign timer_pend   = mstatus_mie & mie[MIE_MTIE] & irq_timer;
    assign latched_live = irq_live(cause_q[3:0], ext_pend, sw_pend, timer_pend);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        is_mret_d = is_mret_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    cause_d   = {60'd0, exc_code};
                    epc_d     = exc_pc;
                    is_mret_d = 1'b0;
                    state_d   = ST_COMMIT;
                end else if (mret_valid) begin
                    is_mret_d = 1'b1;
                    state_d   = ST_COMMIT;
                end else if (irq_valid) begin
                    cause_d   = irq_cause;
                    is_mret_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (exc_valid) begin
                    cause_d   = {60'd0, exc_code};
                    epc_d     = exc_pc;
                    is_mret_d = 1'b0;
                    state_d   = ST_COMMIT;
                end else if (mret_valid) begin
                    // MRET already reached W; it retires instead of the irq
                    is_mret_d = 1'b1;
                    state_d   = ST_COMMIT;
                end else if (!latched_live) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= CW'(THR) && !pipe_busy && commit_pc_valid) begin
                    epc_d   = commit_pc;
                    state_d = ST_COMMIT;
                end else if (cnt_q != CW'(THR)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            is_mret_q <= is_mret_d;
        end
    end

    assign stall_fetch    = (state_q == ST_DRAIN) || (state_q == ST_COMMIT);
    assign flush          = (state_q == ST_COMMIT);
    assign trap_req       = (state_q == ST_COMMIT) && !is_mret_q;
    assign mret_req       = (state_q == ST_COMMIT) && is_mret_q;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_sel   = (state_q == ST_REDIRECT) && is_mret_q;
    assign busy           = (state_q != ST_IDLE);
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;

    logic unused_mie;
    assign unused_mie = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0], cause_q[62:4]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Control outputs are compared as one vector
// {stall_fetch, trap_req, mret_req, flush, redirect_valid, redirect_sel, busy}.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, mret_valid, irq_ext, irq_sw, irq_timer;
    logic        mstatus_mie, commit_pc_valid, pipe_busy;
    logic [3:0]  exc_code;
    logic [63:0] exc_pc, mie, commit_pc;
    logic        stall_fetch, trap_req, mret_req, flush, redirect_valid, redirect_sel, busy;
    logic [63:0] trap_cause, trap_epc;
    logic [6:0]  obs;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_DRAIN  = 7'b1000001;
    localparam logic [6:0] O_TRAP   = 7'b1101001;
    localparam logic [6:0] O_MRET   = 7'b1011001;
    localparam logic [6:0] O_RD_VEC = 7'b0000101;
    localparam logic [6:0] O_RD_EPC = 7'b0000111;

    always #5 clk = ~clk;

    trap_ctrl #(.MIN_DRAIN(3)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_valid(mret_valid),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .mstatus_mie(mstatus_mie), .mie(mie),
        .commit_pc(commit_pc), .commit_pc_valid(commit_pc_valid),
        .pipe_busy(pipe_busy),
        .stall_fetch(stall_fetch), .trap_req(trap_req),
        .trap_cause(trap_cause), .trap_epc(trap_epc),
        .mret_req(mret_req), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .busy(busy)
    );

    assign obs = {stall_fetch, trap_req, mret_req, flush, redirect_valid, redirect_sel, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; mret_valid = 0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
        mstatus_mie = 0; commit_pc_valid = 0; pipe_busy = 0;
        exc_code = 0; exc_pc = 0; mie = 0; commit_pc = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL reset_outs got %b want %b", obs, O_IDLE); end
        n_cmp++; if (trap_cause !== 64'd0) begin n_bad++; $display("FAIL reset_cause got %h want 0", trap_cause); end
        n_cmp++; if (trap_epc !== 64'd0) begin n_bad++; $display("FAIL reset_epc got %h want 0", trap_epc); end
        reset = 1;
    endtask

    task automatic test_exception();
        exc_valid = 1; exc_code = 4'd2; exc_pc = 64'h8000_0010;
        step();
        exc_valid = 0; exc_code = 0; exc_pc = 0;
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL exc_commit got %b want %b", obs, O_TRAP); end
        n_cmp++; if (trap_cause !== 64'h2) begin n_bad++; $display("FAIL exc_cause got %h want 2", trap_cause); end
        n_cmp++; if (trap_epc !== 64'h8000_0010) begin n_bad++; $display("FAIL exc_epc got %h want 80000010", trap_epc); end
        step();
        n_cmp++; if (obs !== O_RD_VEC) begin n_bad++; $display("FAIL exc_redirect got %b want %b", obs, O_RD_VEC); end
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL exc_idle got %b want %b", obs, O_IDLE); end
        n_cmp++; if (trap_cause !== 64'h2) begin n_bad++; $display("FAIL exc_cause_hold got %h want 2", trap_cause); end
    endtask

    task automatic test_irq_timer();
        mstatus_mie = 1; mie = 64'h80; irq_timer = 1;
        commit_pc = 64'h8000_0100; commit_pc_valid = 1; pipe_busy = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (obs !== O_DRAIN) begin n_bad++; $display("FAIL tmr_drain%0d got %b want %b", i, obs, O_DRAIN); end
            step();
        end
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL tmr_commit got %b want %b", obs, O_TRAP); end
        n_cmp++; if (trap_cause !== 64'h8000_0000_0000_0007) begin n_bad++; $display("FAIL tmr_cause got %h want 8000000000000007", trap_cause); end
        n_cmp++; if (trap_epc !== 64'h8000_0100) begin n_bad++; $display("FAIL tmr_epc got %h want 80000100", trap_epc); end
        irq_timer = 0;
        step();
        n_cmp++; if (obs !== O_RD_VEC) begin n_bad++; $display("FAIL tmr_redirect got %b want %b", obs, O_RD_VEC); end
        step();
        clear_inputs();
    endtask

    // ext beats timer; pipe_busy keeps DRAIN alive past the minimum
    task automatic test_irq_priority();
        mstatus_mie = 1; mie = 64'h880; irq_ext = 1; irq_timer = 1;
        commit_pc = 64'h8000_0300; commit_pc_valid = 1; pipe_busy = 1;
        step();
        n_cmp++; if (trap_cause !== 64'h8000_0000_0000_000B) begin n_bad++; $display("FAIL prio_cause got %h want 800000000000000b", trap_cause); end
        repeat (4) step();
        n_cmp++; if (obs !== O_DRAIN) begin n_bad++; $display("FAIL prio_busy_hold got %b want %b", obs, O_DRAIN); end
        pipe_busy = 0;
        step();
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL prio_commit got %b want %b", obs, O_TRAP); end
        n_cmp++; if (trap_cause !== 64'h8000_0000_0000_000B) begin n_bad++; $display("FAIL prio_cause2 got %h want 800000000000000b", trap_cause); end
        n_cmp++; if (trap_epc !== 64'h8000_0300) begin n_bad++; $display("FAIL prio_epc got %h want 80000300", trap_epc); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_drain_exc_preempt();
        mstatus_mie = 1; mie = 64'h8; irq_sw = 1; pipe_busy = 1; commit_pc_valid = 1;
        step();
        n_cmp++; if (obs !== O_DRAIN) begin n_bad++; $display("FAIL pre_drain got %b want %b", obs, O_DRAIN); end
        exc_valid = 1; exc_code = 4'd4; exc_pc = 64'h8000_0200;
        step();
        clear_inputs();
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL pre_commit got %b want %b", obs, O_TRAP); end
        n_cmp++; if (trap_cause !== 64'h4) begin n_bad++; $display("FAIL pre_cause got %h want 4", trap_cause); end
        n_cmp++; if (trap_epc !== 64'h8000_0200) begin n_bad++; $display("FAIL pre_epc got %h want 80000200", trap_epc); end
        step(); step();
    endtask

    task automatic test_drain_drop();
        mstatus_mie = 1; mie = 64'h80; irq_timer = 1; pipe_busy = 1; commit_pc_valid = 1;
        step();
        n_cmp++; if (obs !== O_DRAIN) begin n_bad++; $display("FAIL drop_drain got %b want %b", obs, O_DRAIN); end
        irq_timer = 0;
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL drop_idle got %b want %b", obs, O_IDLE); end
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL drop_no_trap got %b want %b", obs, O_IDLE); end
        clear_inputs();
    endtask

    task automatic test_reset_in_commit_mret();
        exc_valid = 1; exc_code = 4'd1; exc_pc = 64'h8000_0400;
        step();
        exc_valid = 0;
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL rst_pre_commit got %b want %b", obs, O_TRAP); end
        #2 reset = 0;
        #1;
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL rst_async_outs got %b want %b", obs, O_IDLE); end
        n_cmp++; if ({trap_cause, trap_epc} !== 128'd0) begin n_bad++; $display("FAIL rst_async_regs got %h/%h want 0/0", trap_cause, trap_epc); end
        step();
        reset = 1;
        mret_valid = 1;
        step();
        mret_valid = 0;
        n_cmp++; if (obs !== O_MRET) begin n_bad++; $display("FAIL mret_commit got %b want %b", obs, O_MRET); end
        step();
        n_cmp++; if (obs !== O_RD_EPC) begin n_bad++; $display("FAIL mret_redirect got %b want %b", obs, O_RD_EPC); end
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL mret_idle got %b want %b", obs, O_IDLE); end
    endtask

    // exc_valid held high: REDIRECT ignores it, IDLE takes the next one
    task automatic test_back_to_back();
        exc_valid = 1; exc_code = 4'd6; exc_pc = 64'hA0;
        step();
        n_cmp++; if (trap_cause !== 64'h6) begin n_bad++; $display("FAIL b2b_cause1 got %h want 6", trap_cause); end
        exc_code = 4'd5; exc_pc = 64'hB0;
        step();
        n_cmp++; if (obs !== O_RD_VEC || trap_cause !== 64'h6) begin n_bad++; $display("FAIL b2b_redirect got %b/%h want %b/6", obs, trap_cause, O_RD_VEC); end
        step();
        n_cmp++; if (obs !== O_IDLE) begin n_bad++; $display("FAIL b2b_idle got %b want %b", obs, O_IDLE); end
        step();
        exc_valid = 0;
        n_cmp++; if (obs !== O_TRAP) begin n_bad++; $display("FAIL b2b_commit2 got %b want %b", obs, O_TRAP); end
        n_cmp++; if (trap_cause !== 64'h5 || trap_epc !== 64'hB0) begin n_bad++; $display("FAIL b2b_regs2 got %h/%h want 5/b0", trap_cause, trap_epc); end
        step(); step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq_timer();
        test_irq_priority();
        test_drain_exc_preempt();
        test_drain_drop();
        test_reset_in_commit_mret();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
